// File: rtl/uart_rx_oversampler.sv
// UART receive engine: oversampled start/data/parity/stop deserialiser with
// 3-sample majority voting, false-start rejection, break detection and a
// one-entry valid/ready holding register.
module uart_rx_oversampler #(
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       ov_baud_rt_i,
  input  logic       rx_i,
  input  logic [1:0] data_width_i,
  input  logic       stop_bits_number_i,
  input  logic [1:0] parity_mode_i,
  input  logic       ready_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       break_o,
  output logic       busy_o
);

  localparam int unsigned CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned MID   = OVERSAMPLE / 2;

  localparam logic [CNT_W-1:0] IDX_LO  = CNT_W'(MID - 1);
  localparam logic [CNT_W-1:0] IDX_MID = CNT_W'(MID);
  localparam logic [CNT_W-1:0] IDX_DEC = CNT_W'(MID + 1);
  localparam logic [CNT_W-1:0] IDX_END = CNT_W'(OVERSAMPLE - 1);

  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_START      = 3'd1;
  localparam logic [2:0] S_DATA       = 3'd2;
  localparam logic [2:0] S_PARITY     = 3'd3;
  localparam logic [2:0] S_STOP       = 3'd4;
  localparam logic [2:0] S_BREAK_WAIT = 3'd5;

  // Synchroniser, preset to the idle line level.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  // Frame state.
  logic [2:0]       state_q,      state_n;
  logic [CNT_W-1:0] cnt_q,        cnt_n;
  logic [2:0]       bit_q,        bit_n;
  logic             stop_q,       stop_n;
  logic             s0_q,         s0_n;
  logic             s1_q,         s1_n;
  logic [7:0]       shift_q,      shift_n;
  logic [1:0]       width_q,      width_n;
  logic [1:0]       par_q,        par_n;
  logic             stop2_q,      stop2_n;
  logic             perr_pend_q,  perr_pend_n;
  logic             ferr_pend_q,  ferr_pend_n;
  logic             nonzero_q,    nonzero_n;
  logic             stop0z_q,     stop0z_n;

  // Output registers.
  logic [7:0]       data_q,       data_n;
  logic             valid_q,      valid_n;
  logic             perr_q,       perr_n;
  logic             ferr_q,       ferr_n;
  logic             ovr_q,        ovr_n;
  logic             brk_q,        brk_n;
  logic             busy_q,       busy_n;

  // Combinational helpers.
  logic [CNT_W-1:0] tick_idx_c;
  logic             in_frame_c;
  logic             at_lo_c, at_mid_c, at_dec_c, at_end_c;
  logic             maj_c;
  logic             par_en_c;
  logic             par_exp_c;
  logic             done_c;
  logic             ferr_final_c;
  logic [2:0]       last_bit_c;

  assign rx_s = sync_q[SYNC_STAGES-1];

  // Two-flop (or deeper) synchroniser for the asynchronous serial line.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
    end
  end

  // Sample-point decode and majority vote over the three mid-bit samples.
  always_comb begin
    tick_idx_c = (cnt_q == IDX_END) ? '0 : cnt_q + CNT_W'(1);
    in_frame_c = (state_q == S_START) || (state_q == S_DATA) ||
                 (state_q == S_PARITY) || (state_q == S_STOP);
    at_lo_c    = ov_baud_rt_i && in_frame_c && (tick_idx_c == IDX_LO);
    at_mid_c   = ov_baud_rt_i && in_frame_c && (tick_idx_c == IDX_MID);
    at_dec_c   = ov_baud_rt_i && in_frame_c && (tick_idx_c == IDX_DEC);
    at_end_c   = ov_baud_rt_i && in_frame_c && (tick_idx_c == IDX_END);
    maj_c      = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
    par_en_c   = par_q[0] ^ par_q[1];
    par_exp_c  = (^shift_q) ^ (par_q == PAR_ODD);
    last_bit_c = 3'd4 + {1'b0, width_q};
  end

  // Next-state and datapath update for the receive FSM and holding register.
  always_comb begin
    state_n      = state_q;
    cnt_n        = cnt_q;
    bit_n        = bit_q;
    stop_n       = stop_q;
    s0_n         = s0_q;
    s1_n         = s1_q;
    shift_n      = shift_q;
    width_n      = width_q;
    par_n        = par_q;
    stop2_n      = stop2_q;
    perr_pend_n  = perr_pend_q;
    ferr_pend_n  = ferr_pend_q;
    nonzero_n    = nonzero_q;
    stop0z_n     = stop0z_q;
    data_n       = data_q;
    valid_n      = valid_q;
    perr_n       = perr_q;
    ferr_n       = ferr_q;
    ovr_n        = 1'b0;
    brk_n        = 1'b0;
    done_c       = 1'b0;
    ferr_final_c = ferr_pend_q;

    if (valid_q && ready_i) begin
      valid_n = 1'b0;
    end

    if (ov_baud_rt_i && in_frame_c) begin
      cnt_n = tick_idx_c;
    end
    if (at_lo_c) begin
      s0_n = rx_s;
    end
    if (at_mid_c) begin
      s1_n = rx_s;
    end

    case (state_q)
      S_IDLE: begin
        if (ov_baud_rt_i && !rx_s) begin
          state_n = S_START;
          cnt_n   = '0;
        end
      end

      S_START: begin
        if (at_dec_c) begin
          if (maj_c) begin
            state_n = S_IDLE;
            cnt_n   = '0;
          end else begin
            width_n     = data_width_i;
            par_n       = parity_mode_i;
            stop2_n     = stop_bits_number_i;
            shift_n     = '0;
            bit_n       = '0;
            stop_n      = 1'b0;
            perr_pend_n = 1'b0;
            ferr_pend_n = 1'b0;
            nonzero_n   = 1'b0;
            stop0z_n    = 1'b0;
          end
        end
        if (at_end_c) begin
          state_n = S_DATA;
        end
      end

      S_DATA: begin
        if (at_dec_c) begin
          shift_n[bit_q] = maj_c;
          if (maj_c) begin
            nonzero_n = 1'b1;
          end
        end
        if (at_end_c) begin
          if (bit_q == last_bit_c) begin
            state_n = par_en_c ? S_PARITY : S_STOP;
            stop_n  = 1'b0;
          end else begin
            bit_n = bit_q + 3'd1;
          end
        end
      end

      S_PARITY: begin
        if (at_dec_c) begin
          if (maj_c != par_exp_c) begin
            perr_pend_n = 1'b1;
          end
          if (maj_c) begin
            nonzero_n = 1'b1;
          end
        end
        if (at_end_c) begin
          state_n = S_STOP;
          stop_n  = 1'b0;
        end
      end

      S_STOP: begin
        if (at_dec_c) begin
          ferr_final_c = ferr_pend_q | !maj_c;
          ferr_pend_n  = ferr_final_c;
          if (!stop_q) begin
            stop0z_n = !maj_c;
          end
          // Completion at mid-bit of the last stop bit allows back-to-back frames.
          if (stop_q == stop2_q) begin
            cnt_n = '0;
            if (!nonzero_q && (stop_q ? stop0z_q : !maj_c)) begin
              brk_n   = 1'b1;
              state_n = S_BREAK_WAIT;
            end else begin
              done_c  = 1'b1;
              state_n = S_IDLE;
            end
          end
        end
        if (at_end_c && (stop_q != stop2_q)) begin
          stop_n = 1'b1;
        end
      end

      S_BREAK_WAIT: begin
        if (ov_baud_rt_i && rx_s) begin
          state_n = S_IDLE;
        end
      end

      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase

    // A completed character loads if the slot is free or emptying this cycle.
    if (done_c) begin
      if (!valid_q || ready_i) begin
        data_n  = shift_q;
        perr_n  = perr_pend_q;
        ferr_n  = ferr_final_c;
        valid_n = 1'b1;
      end else begin
        ovr_n = 1'b1;
      end
    end

    busy_n = (state_n != S_IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      stop_q      <= 1'b0;
      s0_q        <= 1'b0;
      s1_q        <= 1'b0;
      shift_q     <= '0;
      width_q     <= '0;
      par_q       <= '0;
      stop2_q     <= 1'b0;
      perr_pend_q <= 1'b0;
      ferr_pend_q <= 1'b0;
      nonzero_q   <= 1'b0;
      stop0z_q    <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
      brk_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      bit_q       <= bit_n;
      stop_q      <= stop_n;
      s0_q        <= s0_n;
      s1_q        <= s1_n;
      shift_q     <= shift_n;
      width_q     <= width_n;
      par_q       <= par_n;
      stop2_q     <= stop2_n;
      perr_pend_q <= perr_pend_n;
      ferr_pend_q <= ferr_pend_n;
      nonzero_q   <= nonzero_n;
      stop0z_q    <= stop0z_n;
      data_q      <= data_n;
      valid_q     <= valid_n;
      perr_q      <= perr_n;
      ferr_q      <= ferr_n;
      ovr_q       <= ovr_n;
      brk_q       <= brk_n;
      busy_q      <= busy_n;
    end
  end

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign parity_err_o = perr_q;
  assign frame_err_o  = ferr_q;
  assign overrun_o    = ovr_q;
  assign break_o      = brk_q;
  assign busy_o       = busy_q;

endmodule
